// File: rtl/operand_issue_stage.sv
// ID->EX issue stage: resolves ALU operands with EX/MEM bypass, stalls on load-use, registers ALU inputs.
// Latency 1 cycle; a held entry blocks intake until out_ready, load-use inserts a bubble, flush squashes.
module operand_issue_stage #(
    parameter int XLEN        = 32,
    parameter int REG_AW      = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [6:0]             in_opcode,
    input  logic [2:0]             in_func3,
    input  logic [6:0]             in_func7,
    input  logic [REG_AW-1:0]      in_rs1,
    input  logic [REG_AW-1:0]      in_rs2,
    input  logic [REG_AW-1:0]      in_rd,
    input  logic [XLEN-1:0]        in_imm,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [XLEN-1:0]        rs1_data,
    input  logic [XLEN-1:0]        rs2_data,
    input  logic                   ex_wr_en,
    input  logic [REG_AW-1:0]      ex_rd,
    input  logic [XLEN-1:0]        ex_data,
    input  logic                   ex_is_load,
    input  logic                   mem_wr_en,
    input  logic [REG_AW-1:0]      mem_rd,
    input  logic [XLEN-1:0]        mem_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [6:0]             out_opcode,
    output logic [2:0]             out_func3,
    output logic [6:0]             out_func7,
    output logic [XLEN-1:0]        out_operand1,
    output logic [XLEN-1:0]        out_operand2,
    output logic [XLEN-1:0]        out_store_data,
    output logic [REG_AW-1:0]      out_rd,
    output logic [XLEN-1:0]        out_pc,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_L  = 7'b0000011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;

    typedef struct packed {
        logic [6:0]        opcode;
        logic [2:0]        func3;
        logic [6:0]        func7;
        logic [XLEN-1:0]   operand1;
        logic [XLEN-1:0]   operand2;
        logic [XLEN-1:0]   store_data;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   pc;
    } issue_t;

    issue_t                 issue_q, issue_d;
    logic                   out_valid_q;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            uses_rs1, uses_rs2;
    logic            load_use;
    logic            capture;
    logic            bubble;

    // x0 reads as zero and is never a bypass source; the younger EX result wins over MEM.
    function automatic logic [XLEN-1:0] resolve(
        input logic [REG_AW-1:0] idx,
        input logic [XLEN-1:0]   rf_data,
        input logic              ex_en,
        input logic [REG_AW-1:0] ex_idx,
        input logic [XLEN-1:0]   ex_val,
        input logic              mem_en,
        input logic [REG_AW-1:0] mem_idx,
        input logic [XLEN-1:0]   mem_val
    );
        logic [XLEN-1:0] r;
        if (idx == '0)
            r = '0;
        else if (ex_en && ex_idx == idx)
            r = ex_val;
        else if (mem_en && mem_idx == idx)
            r = mem_val;
        else
            r = rf_data;
        return r;
    endfunction

    always_comb begin
        rs1_val = resolve(in_rs1, rs1_data, ex_wr_en, ex_rd, ex_data, mem_wr_en, mem_rd, mem_data);
        rs2_val = resolve(in_rs2, rs2_data, ex_wr_en, ex_rd, ex_data, mem_wr_en, mem_rd, mem_data);
    end

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (in_opcode)
            OP_R, OP_B:       begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_S:             begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_I, OP_L, JALR: uses_rs1 = 1'b1;
            default:          ;
        endcase
    end

    // A load still in EX has no data yet, so a dependent instruction must wait a cycle.
    always_comb begin
        load_use = in_valid && ex_is_load && ex_wr_en && (ex_rd != '0) &&
                   ((uses_rs1 && ex_rd == in_rs1) || (uses_rs2 && ex_rd == in_rs2));
    end

    always_comb begin
        issue_d            = '0;
        issue_d.opcode     = in_opcode;
        issue_d.func3      = in_func3;
        issue_d.func7      = in_func7;
        issue_d.store_data = rs2_val;
        issue_d.rd         = in_rd;
        issue_d.pc         = in_pc;
        case (in_opcode)
            OP_R, OP_B: begin
                issue_d.operand1 = rs1_val;
                issue_d.operand2 = rs2_val;
            end
            OP_I, OP_L, OP_S: begin
                issue_d.operand1 = rs1_val;
                issue_d.operand2 = in_imm;
            end
            AUIPC, JAL, JALR: begin
                issue_d.operand1 = in_pc;
                issue_d.operand2 = in_imm;
            end
            LUI: begin
                issue_d.operand1 = '0;
                issue_d.operand2 = in_imm;
            end
            default: begin
                issue_d.operand1 = '0;
                issue_d.operand2 = '0;
            end
        endcase
    end

    assign in_ready = !rst && !flush && !load_use && (!out_valid_q || out_ready);
    assign capture  = in_valid && in_ready;
    assign bubble   = !flush && load_use && (out_ready || !out_valid_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_q     <= '0;
            out_valid_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (capture) begin
                issue_q     <= issue_d;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (bubble && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_opcode     = issue_q.opcode;
    assign out_func3      = issue_q.func3;
    assign out_func7      = issue_q.func7;
    assign out_operand1   = issue_q.operand1;
    assign out_operand2   = issue_q.operand2;
    assign out_store_data = issue_q.store_data;
    assign out_rd         = issue_q.rd;
    assign out_pc         = issue_q.pc;
    assign stall_cnt      = stall_cnt_q;

endmodule
